// File: rtl/prefix_scan_pkg.sv
// Shared types for the streaming prefix-scan stage: default widths, result record, FSM states.
// Stages that reuse stream_skid size their payload from $bits of their own record type.
package prefix_scan_pkg;

    localparam int SCAN_N     = 16;
    localparam int SCAN_IDX_W = 8;

    typedef struct packed {
        logic [SCAN_N-1:0]     incl;
        logic [SCAN_N-1:0]     excl;
        logic [SCAN_IDX_W-1:0] idx;
        logic                  last;
        logic                  ovf;
    } scan_res_t;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } scan_state_t;

endpackage

// File: rtl/prefix_scan_stream_if.sv
// Operand stream in and result stream out of prefix_scan_stream, each with valid/ready.
// master = the surrounding producer/consumer, slave = the scan stage.
interface prefix_scan_stream_if #(
    parameter int N     = 16,
    parameter int IDX_W = 8
);
    logic             IN_valid;
    logic             IN_ready;
    logic [N-1:0]     IN_val;
    logic             IN_last;
    logic             OUT_valid;
    logic             OUT_ready;
    logic [N-1:0]     OUT_incl;
    logic [N-1:0]     OUT_excl;
    logic [IDX_W-1:0] OUT_idx;
    logic             OUT_last;
    logic             OUT_ovf;

    modport master (
        output IN_valid, IN_val, IN_last, OUT_ready,
        input  IN_ready, OUT_valid, OUT_incl, OUT_excl, OUT_idx, OUT_last, OUT_ovf
    );

    modport slave (
        input  IN_valid, IN_val, IN_last, OUT_ready,
        output IN_ready, OUT_valid, OUT_incl, OUT_excl, OUT_idx, OUT_last, OUT_ovf
    );
endinterface

// File: rtl/prefix_scan_stream_skid.sv
// Output register plus one skid entry; 1-cycle latency, full throughput.
// in_rdy is registered (= skid empty), so no combinational ready path from out_rdy.
module stream_skid #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_vld,
    output logic         in_rdy,
    input  logic [W-1:0] in_dat,
    output logic         out_vld,
    input  logic         out_rdy,
    output logic [W-1:0] out_dat
);
    logic         skid_vld;
    logic [W-1:0] skid_dat;
    logic         in_fire;
    logic         out_free;

    assign in_rdy   = !skid_vld;
    assign in_fire  = in_vld && in_rdy;
    assign out_free = !out_vld || out_rdy;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_vld  <= 1'b0;
            out_dat  <= '0;
            skid_vld <= 1'b0;
            skid_dat <= '0;
        end else if (out_free) begin
            // A full skid means in_rdy is low, so it never competes with in_fire here.
            if (skid_vld) begin
                out_dat  <= skid_dat;
                out_vld  <= 1'b1;
                skid_vld <= 1'b0;
            end else if (in_fire) begin
                out_dat <= in_dat;
                out_vld <= 1'b1;
            end else begin
                out_vld <= 1'b0;
            end
        end else if (in_fire) begin
            skid_dat <= in_dat;
            skid_vld <= 1'b1;
        end
    end
endmodule

// File: rtl/prefix_scan_stream.sv
// Framed streaming prefix sum (inclusive, exclusive, index, sticky ovf); 1-cycle latency.
// Consumer stalls are absorbed by a registered output plus one skid entry; IN_ready is registered.
module prefix_scan_stream
    import prefix_scan_pkg::*;
#(
    parameter int N     = SCAN_N,
    parameter int IDX_W = SCAN_IDX_W
) (
    input logic                 clk,
    input logic                 rst_n,
    prefix_scan_stream_if.slave bus
);
    // Same layout as scan_res_t, sized by this instance's parameters.
    typedef struct packed {
        logic [N-1:0]     incl;
        logic [N-1:0]     excl;
        logic [IDX_W-1:0] idx;
        logic             last;
        logic             ovf;
    } res_t;

    scan_state_t      state, state_nxt;
    logic [N-1:0]     acc, acc_eff;
    logic [IDX_W-1:0] idx, idx_eff;
    logic             ovf, ovf_eff;
    logic [N:0]       sum;
    logic             in_rdy;
    logic             in_fire;
    res_t             res, out_res;

    assign in_fire = bus.IN_valid && in_rdy;

    always_comb begin
        acc_eff = (state == IDLE) ? '0 : acc;
        idx_eff = (state == IDLE) ? '0 : idx;
        ovf_eff = (state == IDLE) ? 1'b0 : ovf;
        sum     = {1'b0, acc_eff} + {1'b0, bus.IN_val};
        res      = '0;
        res.incl = sum[N-1:0];
        res.excl = acc_eff;
        res.idx  = idx_eff;
        res.last = bus.IN_last;
        res.ovf  = ovf_eff | sum[N];
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (in_fire && !bus.IN_last) state_nxt = RUN;
            RUN:     if (in_fire && bus.IN_last)  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            acc   <= '0;
            idx   <= '0;
            ovf   <= 1'b0;
        end else begin
            state <= state_nxt;
            if (in_fire) begin
                if (bus.IN_last) begin
                    acc <= '0;
                    idx <= '0;
                    ovf <= 1'b0;
                end else begin
                    acc <= res.incl;
                    idx <= idx_eff + IDX_W'(1);
                    ovf <= res.ovf;
                end
            end
        end
    end

    stream_skid #(.W($bits(res_t))) u_skid (
        .clk     (clk),
        .rst_n   (rst_n),
        .in_vld  (bus.IN_valid),
        .in_rdy  (in_rdy),
        .in_dat  (res),
        .out_vld (bus.OUT_valid),
        .out_rdy (bus.OUT_ready),
        .out_dat (out_res)
    );

    assign bus.IN_ready = in_rdy;
    assign bus.OUT_incl = out_res.incl;
    assign bus.OUT_excl = out_res.excl;
    assign bus.OUT_idx  = out_res.idx;
    assign bus.OUT_last = out_res.last;
    assign bus.OUT_ovf  = out_res.ovf;
endmodule

// File: tb/tb_prefix_scan_stream.sv
// Bench for prefix_scan_stream: table-driven frames, stall/skid, idx wrap and mid-stall reset.
module tb_prefix_scan_stream;

    typedef struct {
        logic [15:0] incl;
        logic [15:0] excl;
        logic [7:0]  idx;
        logic        last;
        logic        ovf;
    } exp_t;

    typedef struct {
        logic [15:0] v;
        logic        l;
        exp_t        e;
    } vec_t;

    logic clk;
    logic rst_n;
    int   n_pass  = 0;
    int   n_check = 0;
    int   stalls  = 0;
    exp_t sb[$];

    prefix_scan_stream_if #(.N(16), .IDX_W(8)) bus ();

    prefix_scan_stream #(.N(16), .IDX_W(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_check++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
    endtask

    function automatic exp_t mk(input logic [15:0] incl, input logic [15:0] excl,
                                input logic [7:0] idx, input logic last, input logic ovf);
        exp_t e;
        e.incl = incl; e.excl = excl; e.idx = idx; e.last = last; e.ovf = ovf;
        return e;
    endfunction

    // Called at posedge+1; returns at posedge+1 after the accepting edge.
    task automatic send(input logic [15:0] v, input logic l, input exp_t e);
        logic ok;
        int   n;
        bus.IN_valid = 1'b1;
        bus.IN_val   = v;
        bus.IN_last  = l;
        ok = 1'b0;
        n  = 0;
        while (!ok && n <= 50) begin
            ok = bus.IN_ready;
            @(posedge clk);
            #1;
            if (!ok) n++;
        end
        stalls += n;
        if (ok) sb.push_back(e);
        else check("send_timeout", 32'd0, 32'd1);
    endtask

    task automatic idle();
        bus.IN_valid = 1'b0;
        bus.IN_val   = 16'hDEAD;
        bus.IN_last  = 1'b1;
    endtask

    // Scoreboard: the output handshakes at the next posedge when valid&&ready at negedge.
    always @(negedge clk) begin
        exp_t e;
        if (rst_n && bus.OUT_valid && bus.OUT_ready) begin
            if (sb.size() == 0) begin
                check("unexpected_output", 32'd1, 32'd0);
            end else begin
                e = sb.pop_front();
                check("incl", 32'(bus.OUT_incl), 32'(e.incl));
                check("excl", 32'(bus.OUT_excl), 32'(e.excl));
                check("idx",  32'(bus.OUT_idx),  32'(e.idx));
                check("last", 32'(bus.OUT_last), 32'(e.last));
                check("ovf",  32'(bus.OUT_ovf),  32'(e.ovf));
            end
        end
    end

    task automatic check_reset_outputs(input string tag);
        check({tag, "_out_valid"}, 32'(bus.OUT_valid), 32'd0);
        check({tag, "_out_incl"},  32'(bus.OUT_incl),  32'd0);
        check({tag, "_out_excl"},  32'(bus.OUT_excl),  32'd0);
        check({tag, "_out_idx"},   32'(bus.OUT_idx),   32'd0);
        check({tag, "_out_last"},  32'(bus.OUT_last),  32'd0);
        check({tag, "_out_ovf"},   32'(bus.OUT_ovf),   32'd0);
        check({tag, "_in_ready"},  32'(bus.IN_ready),  32'd1);
    endtask

    task automatic drain(input string tag);
        int n;
        n = 0;
        while (sb.size() != 0 && n < 20) begin
            @(posedge clk);
            #1;
            n++;
        end
        check({tag, "_drain_left"}, 32'(sb.size()), 32'd0);
    endtask

    vec_t vecs[10];

    initial begin
        vecs[0] = '{16'd3,    1'b0, mk(16'd3,    16'd0,    8'd0, 1'b0, 1'b0)};
        vecs[1] = '{16'd5,    1'b0, mk(16'd8,    16'd3,    8'd1, 1'b0, 1'b0)};
        vecs[2] = '{16'd7,    1'b1, mk(16'd15,   16'd8,    8'd2, 1'b1, 1'b0)};
        vecs[3] = '{16'd1,    1'b0, mk(16'd1,    16'd0,    8'd0, 1'b0, 1'b0)};
        vecs[4] = '{16'd1,    1'b1, mk(16'd2,    16'd1,    8'd1, 1'b1, 1'b0)};
        vecs[5] = '{16'hFFF0, 1'b0, mk(16'hFFF0, 16'd0,    8'd0, 1'b0, 1'b0)};
        vecs[6] = '{16'h0020, 1'b0, mk(16'h0010, 16'hFFF0, 8'd1, 1'b0, 1'b1)};
        vecs[7] = '{16'h0001, 1'b1, mk(16'h0011, 16'h0010, 8'd2, 1'b1, 1'b1)};
        vecs[8] = '{16'd5,    1'b1, mk(16'd5,    16'd0,    8'd0, 1'b1, 1'b0)};
        vecs[9] = '{16'd42,   1'b1, mk(16'd42,   16'd0,    8'd0, 1'b1, 1'b0)};

        rst_n = 1'b0;
        bus.OUT_ready = 1'b1;
        idle();
        #3;
        check_reset_outputs("reset");
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Back-to-back frames with the consumer always ready.
        for (int i = 0; i < 10; i++) send(vecs[i].v, vecs[i].l, vecs[i].e);
        idle();
        check("table_stall_cycles", 32'(stalls), 32'd0);
        drain("table");

        // Consumer stall: first result held, second into skid, third waits on IN_ready.
        bus.OUT_ready = 1'b0;
        send(16'd4, 1'b0, mk(16'd4, 16'd0, 8'd0, 1'b0, 1'b0));
        check("stall_latency_valid", 32'(bus.OUT_valid), 32'd1);
        check("stall_latency_incl",  32'(bus.OUT_incl),  32'd4);
        send(16'd6, 1'b0, mk(16'd10, 16'd4, 8'd1, 1'b0, 1'b0));
        check("stall_in_ready_low", 32'(bus.IN_ready), 32'd0);
        check("stall_hold_incl",    32'(bus.OUT_incl), 32'd4);
        fork
            send(16'd9, 1'b1, mk(16'd19, 16'd10, 8'd2, 1'b1, 1'b0));
            begin
                repeat (2) @(posedge clk);
                #1;
                check("stall_hold_valid", 32'(bus.OUT_valid), 32'd1);
                check("stall_hold_incl2", 32'(bus.OUT_incl),  32'd4);
                check("stall_hold_excl",  32'(bus.OUT_excl),  32'd0);
                check("stall_in_ready_still_low", 32'(bus.IN_ready), 32'd0);
                bus.OUT_ready = 1'b1;
            end
        join
        idle();
        drain("stall");

        // Frame of 257 zeros: index wraps 255 -> 0 with no other effect.
        for (int i = 0; i < 257; i++)
            send(16'd0, (i == 256), mk(16'd0, 16'd0, 8'(i), (i == 256), 1'b0));
        idle();
        drain("wrap");

        // Asynchronous reset while the skid is full.
        bus.OUT_ready = 1'b0;
        send(16'd1, 1'b0, mk(16'd1, 16'd0, 8'd0, 1'b0, 1'b0));
        send(16'd5, 1'b0, mk(16'd6, 16'd1, 8'd1, 1'b0, 1'b0));
        idle();
        check("prereset_in_ready", 32'(bus.IN_ready), 32'd0);
        #2;
        rst_n = 1'b0;
        #1;
        check_reset_outputs("midreset");
        sb.delete();
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("postreset_no_output", 32'(bus.OUT_valid), 32'd0);
        bus.OUT_ready = 1'b1;
        send(16'd2, 1'b1, mk(16'd2, 16'd0, 8'd0, 1'b1, 1'b0));
        idle();
        drain("postreset");

        $display("%0d/%0d checks passed", n_pass, n_check);
        $finish;
    end

endmodule

// File: doc/prefix_scan_stream.md
Name: prefix_scan_stream

Overview:
- Sequential streaming prefix-sum stage; sits directly upstream of the combinational PrefixSum block and supplies it with one registered running-sum word per cycle.
- Accepts a framed stream of N-bit operands over valid/ready and emits for each operand:
  - the inclusive running sum;
  - the exclusive running sum;
  - the element index within the frame;
  - a sticky carry-overflow flag.
- Output is registered and skid-buffered, so the consumer may stall without creating combinational ready paths.

Parameters:
- N, 16, operand and sum width in bits
- IDX_W, 8, width of the in-frame element index; wraps modulo 2^IDX_W

Ports:
- clk  in  1  single clock, rising edge
- rst_n  in  1  reset, asynchronous, active-low
- IN_valid  in  1  upstream operand valid
- IN_ready  out  1  stage can accept an operand this cycle
- IN_val  in  N  operand
- IN_last  in  1  operand is the final element of its frame
- OUT_valid  out  1  result valid
- OUT_ready  in  1  downstream accepts result
- OUT_incl  out  N  inclusive sum (acc + IN_val) mod 2^N
- OUT_excl  out  N  exclusive sum (acc before this element)
- OUT_idx  out  IDX_W  index of element within frame, first = 0
- OUT_last  out  1  copy of IN_last for this element
- OUT_ovf  out  1  sticky: some carry out of bit N-1 occurred in this frame, up to and including this element

Behaviour:
- Reset (asynchronous assert, synchronous-safe deassert on clk):
  - OUT_valid=0, OUT_incl=0, OUT_excl=0, OUT_idx=0, OUT_last=0, OUT_ovf=0;
  - IN_ready=1; accumulator=0; index=0; ovf=0; FSM=IDLE; skid entry empty.
- Accept rule: an operand is accepted iff IN_valid && IN_ready on a rising clk.
- FSM:
  - IDLE: acc=0, idx=0, ovf=0. Accept -> RUN, or stay IDLE if IN_last=1 (single-element frame).
  - RUN: accept with IN_last=0 -> RUN; accept with IN_last=1 -> IDLE.
- Per accepted operand v:
  - excl=acc; {c, incl}=acc+v, computed N+1 bits wide;
  - ovf_out = ovf | c;
  - then acc<=incl, idx<=idx+1 (wraps), ovf<=ovf_out;
  - on IN_last, acc, idx and ovf clear to 0 for the next frame.
- Latency: 1 cycle. A result is visible on OUT_* the cycle after acceptance when the output register is free or draining.
- Output buffering: one output register plus a one-entry skid buffer.
  - IN_ready is a registered signal equal to "skid entry empty".
  - When OUT_valid && !OUT_ready and a new operand is accepted, the result goes to the skid entry; IN_ready drops the next cycle.
  - When the output handshakes, the skid entry (if any) moves to the output register the same edge; IN_ready rises the next cycle.
  - OUT_* must hold stable while OUT_valid && !OUT_ready.
- Simultaneous accept and output handshake with skid empty: the new result replaces the output register directly; throughput is 1 per cycle with no bubble.
- Ordering: results leave strictly in acceptance order; no drop, no duplication.
- Wrap-around:
  - sum wraps mod 2^N, with OUT_ovf set from that element to the end of its frame;
  - idx wraps 2^IDX_W-1 -> 0 without any flag.
- A frame longer than 2^IDX_W elements is legal.
- IN_last on the very first element: OUT_excl=0, OUT_idx=0, OUT_last=1; FSM stays IDLE.
- Reset mid-frame or mid-stall: all state is discarded immediately; no partial result is emitted after reset deasserts.
- IN_val and IN_last are ignored when IN_valid=0.

Decomposition:
- Package prefix_scan_pkg:
  - typedef struct packed {incl, excl, idx, last, ovf} scan_res_t, parameterised through localparams N and IDX_W defaults;
  - typedef enum logic {IDLE, RUN} scan_state_t.
- Sub-module stream_skid (parameterised on the payload type width): output register plus one skid entry, with valid/ready in and out. Reused by later streaming stages.
- Top-level module holds the FSM, accumulator, index counter, ovf flag and adder.

Test Plan:
- Frame 3,5,7 (last on 7), OUT_ready=1 -> incl 3,8,15; excl 0,3,8; idx 0,1,2; last 0,0,1; ovf 0; one result per cycle.
- Next frame 1,1 immediately after -> incl 1,2; excl 0,1; idx 0,1; accumulator was cleared by the previous last.
- N=16 frame 0xFFF0,0x0020,0x0001 -> incl 0xFFF0,0x0010,0x0011; ovf 0,1,1; next frame ovf 0.
- Hold OUT_ready=0 while feeding 4,6,9 continuously:
  - first result held stable; second lands in skid; IN_ready=0 from cycle 3;
  - release OUT_ready -> results 4,10,19 in order with no loss.
- Single-element frame 42 with last -> incl 42, excl 0, idx 0, last 1; idx wrap: 257 elements of 0 with IDX_W=8 -> element 256 gives idx 0.
- Assert rst_n=0 mid-frame during a stall -> all OUT_* 0 and IN_ready=1 asynchronously; after release, frame 2 gives incl 2, excl 0.
